color_convert_8x8: RTL and testbench
====================================

COLOR_CONVERT_8X8 -- requirements
Module: color_convert_8x8

Interface
REQ-001 SHALL have port clock  input  1  sole clock, rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port ch  input  $clog2(`CH+1)  channel tag of block_in: 2'b00 Y, 2'b01 Cb, 2'b10 Cr; 2'b11 is ignored.
REQ-004 SHALL have port valid_in  input  1  block_in/ch valid this cycle.
REQ-005 SHALL have port block_in  input  signed 9 x [7:0][7:0]  level-shifted 8x8 block, index [row][col]; Cb/Cr come from the chroma supersampler.
REQ-006 SHALL have port ready_out  output  1  block accepted when valid_in && ready_out.
REQ-007 SHALL have port r_out, g_out, b_out  output  8 each  unsigned pixel colour.
REQ-008 SHALL have port pix_row, pix_col  output  3 each  position of the current output pixel.
REQ-009 SHALL have port valid_out  output  1  pixel valid.
REQ-010 SHALL have port ready_in  input  1  downstream accepts the pixel when valid_out && ready_in.

Function
REQ-011 SHALL implement a state machine with states COLLECT and CONVERT; reset state is COLLECT.
REQ-012 In COLLECT, ready_out SHALL be 1; each accepted block SHALL be stored into its channel buffer (Y/Cb/Cr) and set that channel's present flag.
REQ-013 A repeated channel in COLLECT SHALL overwrite the earlier block; a block tagged 2'b11 SHALL be accepted and discarded.
REQ-014 Transition to CONVERT SHALL occur on the edge where all three present flags are set, including on the edge that stores the last block.
REQ-015 In CONVERT, ready_out SHALL be 0 and valid_in SHALL be ignored.
REQ-016 CONVERT SHALL emit 64 pixels in raster order: (row 0, col 0), (0,1) ... (7,7), with pix_row/pix_col identifying each pixel.
REQ-017 Pixel (0,0) SHALL present valid_out=1 exactly 1 cycle after entering CONVERT (2 cycles with YCC_PIPE_EN).
REQ-018 After ready_in stalls, r/g/b_out, pix_row/pix_col and valid_out SHALL hold stable until the handshake completes.
REQ-019 Throughput SHALL be one pixel per cycle while ready_in=1.
REQ-020 On the handshake of pixel (7,7), the block SHALL clear all present flags and return to COLLECT; ready_out SHALL be 1 on the next cycle.
REQ-021 Arithmetic per pixel (Y, Cb, Cr signed 9-bit; products in signed 20-bit; >>> is arithmetic shift):
  - R = Y + 128 + ((359*Cr + 128) >>> 8)
  - G = Y + 128 - ((88*Cb + 183*Cr + 128) >>> 8)
  - B = Y + 128 + ((454*Cb + 128) >>> 8)
REQ-022 Each result SHALL saturate to 0..255: negative -> 0, >255 -> 255.

Reset
REQ-023 While reset_n=0:
  - state = COLLECT.
  - Present flags and pixel counter = 0.
  - valid_out = 0; r/g/b_out = 0; pix_row/pix_col = 0.
  - ready_out = 1 after deassertion.
REQ-024 Reset asserted mid-CONVERT SHALL abandon the block; no further pixels of it are emitted.
REQ-025 Buffer contents need not be cleared by reset.

Configuration
REQ-026 With macro YCC_PIPE_EN defined, the block SHALL add one register stage between multiply and add/saturate; the whole pipeline stalls on !ready_in.
REQ-027 Without YCC_PIPE_EN, the datapath SHALL be single-stage; output order and results SHALL be identical in both builds, and only latency differs.

Structure
REQ-028 Shared package/sys_defs.svh SHALL hold:
  - channel codes CH_Y/CH_CB/CH_CR.
  - pixel typedef rgb_t (3x8-bit).
  - coefficients 359/88/183/454 and the rounding constant 128.
REQ-029 Per-pixel arithmetic SHALL live in sub-module ycc2rgb_pixel (combinational, plus the optional stage under YCC_PIPE_EN); color_convert_8x8 holds buffers, FSM, counter and handshake.

Verification
REQ-030 Y=0, Cb=0, Cr=0 blocks, ready_in=1 -> 64 pixels of (128,128,128), one per cycle, last at (7,7), then ready_out=1.
REQ-031 Y=127, Cb=0, Cr=127 -> R saturates to 255, G=255-((183*127+128)>>>8)=164, B=255.
REQ-032 Y=-128, Cb=-128, Cr=0 -> B=0 (saturated low), R=0, G=44.
REQ-033 Order Cr, Y, Cb with a second Y overwriting the first -> CONVERT starts on the Cb edge and uses the second Y; blocks offered during CONVERT are not accepted (ready_out=0).
REQ-034 ready_in toggling 1,0,0,1 at pixel (3,5) -> output held stable for the two stalled cycles; no pixel is lost or duplicated across all 64.
REQ-035 reset_n pulsed low at pixel (2,0) -> valid_out=0 immediately; afterwards COLLECT requires three new blocks. Rerun all scenarios with YCC_PIPE_EN and check +1 cycle latency.

Source files
------------

// File: rtl/color_convert_8x8_pkg.sv
// Shared definitions for the 8x8 YCbCr -> RGB block converter.
// Channel codes, pixel type, conversion coefficients and the clamp helper.
package color_convert_8x8_pkg;

  localparam logic [1:0] CH_Y    = 2'b00;
  localparam logic [1:0] CH_CB   = 2'b01;
  localparam logic [1:0] CH_CR   = 2'b10;
  localparam logic [1:0] CH_NONE = 2'b11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic signed [19:0] K_R_CR = 20'sd359;
  localparam logic signed [19:0] K_G_CB = 20'sd88;
  localparam logic signed [19:0] K_G_CR = 20'sd183;
  localparam logic signed [19:0] K_B_CB = 20'sd454;
  localparam logic signed [19:0] K_RND  = 20'sd128;
  localparam logic signed [19:0] Y_OFS  = 20'sd128;

  function automatic logic [7:0] sat8(input logic signed [19:0] v);
    if (v < 20'sd0)        return 8'd0;
    else if (v > 20'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

endpackage

// File: rtl/color_convert_8x8_ycc2rgb.sv
// Per-pixel YCbCr -> RGB arithmetic with saturation.
// With YCC_PIPE_EN the products are registered before the add/saturate step.
module ycc2rgb_pixel
  import color_convert_8x8_pkg::*;
(
`ifdef YCC_PIPE_EN
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
`endif
  input  logic signed [8:0] y,
  input  logic signed [8:0] cb,
  input  logic signed [8:0] cr,
  output rgb_t              rgb
);

  logic signed [19:0] y_w, cb_w, cr_w;
  logic signed [19:0] m_y, m_rcr, m_gcb, m_gcr, m_bcb;
  logic signed [19:0] p_y, p_rcr, p_gcb, p_gcr, p_bcb;
  logic signed [19:0] r_t, g_t, b_t;

  assign y_w  = {{11{y[8]}},  y};
  assign cb_w = {{11{cb[8]}}, cb};
  assign cr_w = {{11{cr[8]}}, cr};

  assign m_y   = y_w;
  assign m_rcr = cr_w * K_R_CR;
  assign m_gcb = cb_w * K_G_CB;
  assign m_gcr = cr_w * K_G_CR;
  assign m_bcb = cb_w * K_B_CB;

`ifdef YCC_PIPE_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_y   <= '0;
      p_rcr <= '0;
      p_gcb <= '0;
      p_gcr <= '0;
      p_bcb <= '0;
    end else if (en) begin
      p_y   <= m_y;
      p_rcr <= m_rcr;
      p_gcb <= m_gcb;
      p_gcr <= m_gcr;
      p_bcb <= m_bcb;
    end
  end
`else
  assign p_y   = m_y;
  assign p_rcr = m_rcr;
  assign p_gcb = m_gcb;
  assign p_gcr = m_gcr;
  assign p_bcb = m_bcb;
`endif

  // all operands signed, so >>> floors toward -inf
  assign r_t = p_y + Y_OFS + ((p_rcr + K_RND) >>> 8);
  assign g_t = p_y + Y_OFS - ((p_gcb + p_gcr + K_RND) >>> 8);
  assign b_t = p_y + Y_OFS + ((p_bcb + K_RND) >>> 8);

  assign rgb = '{sat8(r_t), sat8(g_t), sat8(b_t)};

endmodule

// File: rtl/color_convert_8x8.sv
// 8x8 block colour converter: collects Y/Cb/Cr blocks, then streams 64 RGB pixels.
// Define YCC_PIPE_EN to add a register stage between multiply and add/saturate.
module color_convert_8x8
  import color_convert_8x8_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            ch,
  input  logic                  valid_in,
  input  logic [7:0][7:0][8:0]  block_in,
  output logic                  ready_out,
  output logic [7:0]            r_out,
  output logic [7:0]            g_out,
  output logic [7:0]            b_out,
  output logic [2:0]            pix_row,
  output logic [2:0]            pix_col,
  output logic                  valid_out,
  input  logic                  ready_in
);

  localparam logic COLLECT = 1'b0;
  localparam logic CONVERT = 1'b1;

`ifdef YCC_PIPE_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 0;
`endif

  logic                  state;
  logic [2:0]            present, pres_nxt;
  logic [6:0]            issue_cnt;
  logic                  issue_vld, advance, done, fin_vld;
  logic [7:0][7:0][8:0]  y_buf, cb_buf, cr_buf;
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:0][5:0]  idx_pipe;
  logic [2:0]            i_row, i_col;
  rgb_t                  rgb_c, rgb_q;

  assign ready_out = (state == COLLECT);
  assign issue_vld = (state == CONVERT) && !issue_cnt[6];
  assign {i_row, i_col} = issue_cnt[5:0];

  assign valid_out = vld_pipe[STAGES];
  // any stall at the output freezes every stage, including the issue counter
  assign advance   = !valid_out || ready_in;
  assign done      = valid_out && ready_in && (idx_pipe[STAGES] == 6'd63);
  assign {pix_row, pix_col} = idx_pipe[STAGES];
  assign {r_out, g_out, b_out} = rgb_q;

`ifdef YCC_PIPE_EN
  assign fin_vld = vld_pipe[0];
`else
  assign fin_vld = issue_vld;
`endif

  always_comb begin
    pres_nxt = present;
    if (valid_in) begin
      case (ch)
        CH_Y:    pres_nxt[0] = 1'b1;
        CH_CB:   pres_nxt[1] = 1'b1;
        CH_CR:   pres_nxt[2] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (ready_out && valid_in) begin
      case (ch)
        CH_Y:    y_buf  <= block_in;
        CH_CB:   cb_buf <= block_in;
        CH_CR:   cr_buf <= block_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= COLLECT;
      present   <= '0;
      issue_cnt <= '0;
    end else if (state == COLLECT) begin
      present <= pres_nxt;
      if (&pres_nxt) begin
        state     <= CONVERT;
        issue_cnt <= '0;
      end
    end else begin
      if (advance && issue_vld)
        issue_cnt <= issue_cnt + 7'd1;
      if (done) begin
        state     <= COLLECT;
        present   <= '0;
        issue_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
      rgb_q    <= '0;
    end else if (advance) begin
      vld_pipe[0] <= issue_vld;
      idx_pipe[0] <= issue_cnt[5:0];
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
      if (fin_vld)
        rgb_q <= rgb_c;
    end
  end

  ycc2rgb_pixel u_pix (
`ifdef YCC_PIPE_EN
    .clock   (clock),
    .reset_n (reset_n),
    .en      (advance),
`endif
    .y       (y_buf[i_row][i_col]),
    .cb      (cb_buf[i_row][i_col]),
    .cr      (cr_buf[i_row][i_col]),
    .rgb     (rgb_c)
  );

endmodule

// File: tb/tb_color_convert_8x8.sv
// Self-checking bench for color_convert_8x8 (either build of YCC_PIPE_EN).
// Integer reference model of the conversion plus directed block scenarios.
module tb_color_convert_8x8;

`ifdef YCC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clock, reset_n, valid_in, ready_out, valid_out, ready_in;
  logic [1:0]           ch;
  logic [7:0][7:0][8:0] block_in;
  logic [7:0]           r_out, g_out, b_out;
  logic [2:0]           pix_row, pix_col;

  color_convert_8x8 dut (
    .clock(clock), .reset_n(reset_n), .ch(ch), .valid_in(valid_in),
    .block_in(block_in), .ready_out(ready_out), .r_out(r_out), .g_out(g_out),
    .b_out(b_out), .pix_row(pix_row), .pix_col(pix_col),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0, passes = 0;
  int m_buf [3][64];
  bit m_pres [3];
  bit m_conv = 0;
  bit mon_en = 0;
  int exp_cnt = 0;
  int last_r, last_g, last_b, last_pos;
  int va [64], vb [64], vc [64];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic void model(input int y, input int cb, input int cr,
                                output int r, output int g, output int b);
    r = sat(y + 128 + ((359 * cr + 128) >>> 8));
    g = sat(y + 128 - ((88 * cb + 183 * cr + 128) >>> 8));
    b = sat(y + 128 + ((454 * cb + 128) >>> 8));
  endfunction

  function automatic int wrap9(input int x);
    return (((x + 256) % 512) + 512) % 512 - 256;
  endfunction

  task automatic fill(input int which, input int base, input int step);
    for (int i = 0; i < 64; i++) begin
      case (which)
        0: va[i] = wrap9(base + step * i);
        1: vb[i] = wrap9(base + step * i);
        default: vc[i] = wrap9(base + step * i);
      endcase
    end
  endtask

  task automatic send(input logic [1:0] c, input int v [64]);
    @(posedge clock); #1;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        block_in[r][k] = 9'(v[r*8+k]);
    ch = c;
    valid_in = 1'b1;
    @(negedge clock);
    chk("ready_out_on_offer", int'(ready_out), m_conv ? 0 : 1);
    @(posedge clock); #1;
    valid_in = 1'b0;
    if (!m_conv && c != 2'b11) begin
      for (int i = 0; i < 64; i++) m_buf[c][i] = v[i];
      m_pres[c] = 1'b1;
      if (m_pres[0] && m_pres[1] && m_pres[2]) begin
        m_conv  = 1'b1;
        exp_cnt = 0;
      end
    end
  endtask

  task automatic wait_done(input bit check_lat);
    int n, k;
    if (check_lat) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!valid_out && n < 10);
      chk("first_pixel_latency", n, LAT + 1);
      chk("ready_out_in_convert", int'(ready_out), 0);
    end
    k = 0;
    while (m_conv && k < 300) begin
      @(negedge clock); #1;
      k++;
    end
    chk("block_finished_in_time", int'(m_conv), 0);
    @(negedge clock);
    chk("ready_out_after_block", int'(ready_out), 1);
    chk("valid_out_after_block", int'(valid_out), 0);
  endtask

  task automatic find_pixel(input int row, input int col);
    bit found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clock); #1;
      found = valid_out && pix_row == 3'(row) && pix_col == 3'(col);
    end
    chk("pixel_reached", int'(found), 1);
  endtask

  // one compare process: every handshake against the model, holds during stalls
  logic [30:0] held;
  bit prev_stall = 0;
  always @(negedge clock) begin
    int r, g, b;
    if (!mon_en) prev_stall = 0;
    else begin
      if (prev_stall)
        chk("hold_while_stalled",
            int'({valid_out, pix_row, pix_col, r_out, g_out, b_out} == held), 1);
      if (m_conv && exp_cnt > 0 && exp_cnt < 64)
        chk("no_gap", int'(valid_out), 1);
      if (valid_out && ready_in) begin
        chk("pixel_expected", int'(m_conv), 1);
        if (m_conv) begin
          model(m_buf[0][exp_cnt], m_buf[1][exp_cnt], m_buf[2][exp_cnt], r, g, b);
          chk("pix_position", int'(pix_row) * 8 + int'(pix_col), exp_cnt);
          chk("r_out", int'(r_out), r);
          chk("g_out", int'(g_out), g);
          chk("b_out", int'(b_out), b);
          last_r = r_out; last_g = g_out; last_b = b_out;
          last_pos = int'(pix_row) * 8 + int'(pix_col);
          exp_cnt++;
          if (exp_cnt == 64) begin
            m_conv = 0;
            m_pres = '{0, 0, 0};
          end
        end
      end
      prev_stall = valid_out && !ready_in;
      held = {valid_out, pix_row, pix_col, r_out, g_out, b_out};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, g, b;
    reset_n = 0; valid_in = 0; ch = 2'b00; block_in = '0; ready_in = 1;
    m_pres = '{0, 0, 0};
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_valid_out", int'(valid_out), 0);
    chk("reset_rgb", int'({r_out, g_out, b_out}), 0);
    chk("reset_pix", int'({pix_row, pix_col}), 0);
    @(posedge clock); #1;
    reset_n = 1; mon_en = 1;
    @(negedge clock);
    chk("ready_out_after_reset", int'(ready_out), 1);

    // pin the model to hand-computed values
    model(127, 0, 127, r, g, b);
    chk("model_sat_hi_r", r, 255); chk("model_sat_hi_g", g, 164); chk("model_sat_hi_b", b, 255);
    model(-128, -128, 0, r, g, b);
    chk("model_sat_lo_r", r, 0); chk("model_sat_lo_g", g, 44); chk("model_sat_lo_b", b, 0);

    // all-zero blocks -> mid grey
    fill(0, 0, 0); fill(1, 0, 0); fill(2, 0, 0);
    send(2'b00, va); send(2'b01, vb); send(2'b10, vc);
    wait_done(1);
    chk("grey_r", last_r, 128); chk("grey_g", last_g, 128); chk("grey_b", last_b, 128);
    chk("grey_last_pos", last_pos, 63);

    // saturation high
    fill(0, 127, 0); fill(1, 0, 0); fill(2, 127, 0);
    send(2'b00, va); send(2'b01, vb); send(2'b10, vc);
    wait_done(1);
    chk("sat_hi_r", last_r, 255); chk("sat_hi_g", last_g, 164); chk("sat_hi_b", last_b, 255);

    // saturation low
    fill(0, -128, 0); fill(1, -128, 0); fill(2, 0, 0);
    send(2'b00, va); send(2'b01, vb); send(2'b10, vc);
    wait_done(1);
    chk("sat_lo_r", last_r, 0); chk("sat_lo_g", last_g, 44); chk("sat_lo_b", last_b, 0);

    // full-range ramps, discarded tag-3 block first, order Cb, Cr, Y
    fill(0, 77, 0); send(2'b11, va);
    fill(0, -256, 9); fill(1, 200, -13); fill(2, -37, 29);
    send(2'b01, vb); send(2'b10, vc); send(2'b00, va);
    wait_done(1);

    // Cr, Y, Y (overwrite), Cb, then a block offered during CONVERT
    fill(2, 90, -11); send(2'b10, vc);
    fill(0, 50, 3);   send(2'b00, va);
    fill(0, -60, 5);  send(2'b00, va);
    fill(1, -120, 4); send(2'b01, vb);
    fill(0, 255, 0);  send(2'b00, va);
    wait_done(0);

    // two-cycle stall at pixel (3,5)
    fill(0, 10, 17); fill(1, -90, 7); fill(2, 120, -9);
    send(2'b00, va); send(2'b01, vb); send(2'b10, vc);
    find_pixel(3, 5);
    ready_in = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    ready_in = 1;
    wait_done(0);

    // reset in the middle of a block
    fill(0, -30, 6); fill(1, 40, -3); fill(2, -70, 11);
    send(2'b00, va); send(2'b01, vb); send(2'b10, vc);
    find_pixel(2, 0);
    mon_en = 0;
    reset_n = 0;
    #1;
    chk("abort_valid_out", int'(valid_out), 0);
    chk("abort_rgb", int'({r_out, g_out, b_out}), 0);
    chk("abort_pix", int'({pix_row, pix_col}), 0);
    m_conv = 0; m_pres = '{0, 0, 0}; exp_cnt = 0;
    @(posedge clock); #1;
    reset_n = 1;
    @(posedge clock); #1;
    mon_en = 1;
    fill(0, 33, -5); fill(1, -7, 13); fill(2, 64, -2);
    send(2'b00, va); send(2'b01, vb);
    repeat (3) begin
      @(negedge clock);
      chk("partial_no_output", int'(valid_out), 0);
      chk("partial_still_collect", int'(ready_out), 1);
    end
    send(2'b10, vc);
    wait_done(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
